// File: rtl/ram_arb_pkg.sv
// Shared encodings for the port-A RAM arbiter: FSM states, master ids and
// the byte-lane select patterns the data memory accepts.
package ram_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_GNT0 = 2'd1;
  localparam arb_state_t ST_GNT1 = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [3:0] SEL_B0 = 4'b0001;
  localparam logic [3:0] SEL_B1 = 4'b0010;
  localparam logic [3:0] SEL_B2 = 4'b0100;
  localparam logic [3:0] SEL_B3 = 4'b1000;
  localparam logic [3:0] SEL_H0 = 4'b0011;
  localparam logic [3:0] SEL_H1 = 4'b1100;
  localparam logic [3:0] SEL_W  = 4'b1111;

endpackage

// File: rtl/ram_sel_legal.sv
// Byte-lane select legality: single bytes, aligned halfwords or the full word.
module ram_sel_legal
  import ram_arb_pkg::*;
(
  input  logic [3:0] sel,
  output logic       legal
);

  always_comb begin
    case (sel)
      SEL_B0, SEL_B1, SEL_B2, SEL_B3, SEL_H0, SEL_H1, SEL_W: legal = 1'b1;
      default:                                               legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing BRAM port A between the CPU (m0) and DMA (m1),
// with burst lock, starvation cap, sel legality check and tagged read return.
//   state   | meaning
//   IDLE    | nobody owns port A, ram outputs driven to zero
//   GNT0    | m0 owns port A, a beat completes on every edge m0_req is high
//   GNT1    | m1 owns port A, a beat completes on every edge m1_req is high
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  rawclk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic                  m0_we,
  input  logic [3:0]            m0_sel,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic                  m1_we,
  input  logic [3:0]            m1_sel,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic                  ram_we,
  output logic [3:0]            ram_sel,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int CW = $clog2(MAX_LOCK) + 1;
  localparam logic [CW-1:0] LOCK_CAP = CW'(MAX_LOCK - 1);

  arb_state_t    state, state_nxt;
  logic          last_owner, last_owner_nxt;
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic [1:0]    rd_pend, err_q;
  logic          legal0, legal1;
  logic          gnt0, gnt1, beat0, beat1;
  logic          own_req, own_lock, oth_req;

  ram_sel_legal u_legal0 (.sel(m0_sel), .legal(legal0));
  ram_sel_legal u_legal1 (.sel(m1_sel), .legal(legal1));

  assign gnt0  = (state == ST_GNT0);
  assign gnt1  = (state == ST_GNT1);
  assign beat0 = gnt0 && m0_req;
  assign beat1 = gnt1 && m1_req;

  // Owner/other view so the grant-state rules are written once for both masters.
  always_comb begin
    own_req  = gnt1 ? m1_req  : m0_req;
    own_lock = gnt1 ? m1_lock : m0_lock;
    oth_req  = gnt1 ? m0_req  : m1_req;
  end

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    lock_cnt_nxt   = lock_cnt;
    case (state)
      ST_IDLE: begin
        if (m0_req && m1_req) state_nxt = (last_owner == M1) ? ST_GNT0 : ST_GNT1;
        else if (m0_req)      state_nxt = ST_GNT0;
        else if (m1_req)      state_nxt = ST_GNT1;
      end
      ST_GNT0, ST_GNT1: begin
        last_owner_nxt = gnt1 ? M1 : M0;
        if (own_req && own_lock && (!oth_req || lock_cnt < LOCK_CAP)) begin
          // Only beats taken while the other master waits count toward the cap.
          if (oth_req) lock_cnt_nxt = lock_cnt + 1'b1;
        end else begin
          lock_cnt_nxt = '0;
          if (oth_req)       state_nxt = gnt1 ? ST_GNT0 : ST_GNT1;
          else if (!own_req) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rawclk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_owner <= M1;
      lock_cnt   <= '0;
      rd_pend    <= '0;
      err_q      <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      lock_cnt   <= lock_cnt_nxt;
      rd_pend    <= {beat1 && !m1_we && legal1, beat0 && !m0_we && legal0};
      err_q      <= {beat1 && !legal1, beat0 && !legal0};
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_sel  = '0;
    ram_addr = '0;
    ram_d    = '0;
    if (gnt0) begin
      ram_we   = m0_req && m0_we && legal0;
      ram_sel  = m0_sel;
      ram_addr = m0_addr;
      ram_d    = m0_wdata;
    end else if (gnt1) begin
      ram_we   = m1_req && m1_we && legal1;
      ram_sel  = m1_sel;
      ram_addr = m1_addr;
      ram_d    = m1_wdata;
    end
  end

  // The read tag steers ram_q back to the issuing master even if ownership moved.
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rd_pend[0];
  assign m1_rvalid = rd_pend[1];
  assign m0_rdata  = rd_pend[0] ? ram_q : '0;
  assign m1_rdata  = rd_pend[1] ? ram_q : '0;
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];

endmodule
